pipe_stage_buf: RTL

- Parametrised, elastic pipeline-stage register, the successor to the fixed IF/ID, ID/EX and EX/MEM latches.
- Carries one WIDTH-bit bundle between adjacent stages: packed PC, instruction, operands, immediate and control bits, as packed by the instantiating stage.
- Adds what the plain latches lack:
  - a valid/ready handshake with a 2-entry skid buffer, so back-pressure never loses data;
  - a synchronous flush that inserts a bubble;
  - asynchronous reset;
  - a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_buf.sv | 80 ++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: a main slot feeds the next stage and a
// skid slot absorbs the bundle accepted in the cycle back-pressure arrives.
module pipe_stage_buf #(
   parameter int                 WIDTH        = 32,
   parameter logic [WIDTH-1:0]   BUBBLE_VALUE = {WIDTH{1'b0}},
   parameter int                 CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   input  logic               out_ready,
   input  logic               flush,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_cnt,
   input  logic               clr_cnt
);

   logic               main_v;
   logic [WIDTH-1:0]   main_d;
   logic               skid_v;
   logic [WIDTH-1:0]   skid_d;
   logic               accept;
   logic               consume;
   logic               main_free;

   // in_ready comes from a flop only, so no out_ready -> in_ready path exists
   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign out_data  = main_d;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

   assign accept    = in_valid & in_ready;
   assign consume   = main_v & out_ready;
   assign main_free = ~main_v | consume;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v <= 1'b0;
         main_d <= BUBBLE_VALUE;
         skid_v <= 1'b0;
         skid_d <= BUBBLE_VALUE;
      end else if (flush) begin
         main_v <= 1'b0;
         main_d <= BUBBLE_VALUE;
         skid_v <= 1'b0;
         skid_d <= BUBBLE_VALUE;
      end else if (main_free) begin
         if (skid_v) begin
            main_v <= 1'b1;
            main_d <= skid_d;
            skid_v <= 1'b0;
            skid_d <= BUBBLE_VALUE;
         end else if (accept) begin
            main_v <= 1'b1;
            main_d <= in_data;
         end else begin
            main_v <= 1'b0;
            main_d <= BUBBLE_VALUE;
         end
      end else if (accept) begin
         skid_v <= 1'b1;
         skid_d <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (clr_cnt) begin
         stall_cnt <= '0;
      end else if (main_v && !out_ready && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
